pio_out_wdog: RTL

Parametrised Avalon-MM slave output port. It drives WIDTH enable lines (motor/driver enables) and supports atomic set, clear and toggle writes.
A built-in safety watchdog forces the outputs to a programmable safe pattern if software stops refreshing the block. The trip is sticky and raises an interrupt.
Sits on the processor's Avalon bus as a drop-in for the plain enable PIO; out_port feeds the PWM/H-bridge enable logic.

---
 rtl/pio_wdog_pkg.sv | 24 ++
 rtl/pio_wdog_counter.sv | 55 +++++
 rtl/pio_out_wdog.sv | 117 +++++++++++
 3 files changed

// File: rtl/pio_wdog_pkg.sv
// Shared definitions for the watchdog-protected enable PIO: register map,
// STATUS bit positions and the watchdog state encoding.
package pio_wdog_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_WDOG_LOAD = 3'd4;
  localparam logic [2:0] ADDR_WDOG_KICK = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;
  localparam logic [2:0] ADDR_SAFE      = 3'd7;

  localparam int ST_TRIPPED = 0;
  localparam int ST_RUN     = 1;
  localparam int ST_IRQEN   = 8;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_ARMED   = 2'd1,
    WD_TRIPPED = 2'd2
  } wdog_state_e;

endpackage

// File: rtl/pio_wdog_counter.sv
// Watchdog down-counter: reloads on refresh, trips when it would reach zero,
// and stays tripped until explicitly cleared.
module pio_wdog_counter
  import pio_wdog_pkg::*;
#(
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_CNT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] load_val,
  input  logic             load_wr,
  input  logic             refresh,
  input  logic             clear_trip,
  output logic [CNT_W-1:0] cnt,
  output logic             trip_pulse,
  output logic             tripped
);

  wdog_state_e state;

  // A refresh or a LOAD write in the expiry cycle takes priority over the trip.
  assign trip_pulse = (state == WD_ARMED) && !tripped && !load_wr && !refresh
                      && (cnt == CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= RESET_CNT;
      tripped <= 1'b0;
      state   <= (RESET_CNT != '0) ? WD_ARMED : WD_IDLE;
    end else if (load_wr) begin
      cnt <= load_val;
      if (load_val == '0)   state <= WD_IDLE;
      else if (tripped)     state <= WD_TRIPPED;
      else                  state <= WD_ARMED;
    end else if (clear_trip && tripped) begin
      tripped <= 1'b0;
      cnt     <= load_val;
      state   <= (load_val != '0) ? WD_ARMED : WD_IDLE;
    end else if (tripped) begin
      cnt <= cnt;
    end else if (refresh) begin
      cnt <= load_val;
    end else if (trip_pulse) begin
      cnt     <= '0;
      tripped <= 1'b1;
      state   <= WD_TRIPPED;
    end else if (state == WD_ARMED && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pio_out_wdog.sv
// Avalon-MM enable output port with atomic set/clear/toggle and a sticky
// safety watchdog that forces the outputs to a programmable safe pattern.
module pio_out_wdog
  import pio_wdog_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SAFE_RESET  = '0,
  parameter logic [31:0]      WDOG_RESET  = '0,
  parameter int               CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LOAD_RST = WDOG_RESET[CNT_W-1:0];

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] safe;
  logic [WIDTH-1:0] safe_nxt;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             irq_en;
  logic             tripped;
  logic             trip_pulse;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             load_wr;
  logic             refresh;
  logic             clear_trip;
  logic             running;

  assign wr         = chipselect & ~write_n;
  assign wd         = writedata[WIDTH-1:0];
  assign load_wr    = wr && (address == ADDR_WDOG_LOAD);
  assign refresh    = wr && !tripped
                      && (address <= ADDR_TOGGLE || address == ADDR_WDOG_KICK);
  assign clear_trip = wr && (address == ADDR_STATUS) && writedata[ST_TRIPPED];
  assign load_val   = load_wr ? writedata[CNT_W-1:0] : load;
  assign safe_nxt   = (wr && address == ADDR_SAFE) ? wd : safe;
  assign running    = (load != '0) && !tripped;

  pio_wdog_counter #(
    .CNT_W     (CNT_W),
    .RESET_CNT (LOAD_RST)
  ) u_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_val   (load_val),
    .load_wr    (load_wr),
    .refresh    (refresh),
    .clear_trip (clear_trip),
    .cnt        (cnt),
    .trip_pulse (trip_pulse),
    .tripped    (tripped)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      safe   <= SAFE_RESET;
      load   <= LOAD_RST;
      irq_en <= 1'b0;
    end else if (wr) begin
      if (address == ADDR_SAFE)      safe   <= wd;
      if (address == ADDR_WDOG_LOAD) load   <= writedata[CNT_W-1:0];
      if (address == ADDR_STATUS)    irq_en <= writedata[ST_IRQEN];
    end
  end

  // While tripped (and on the trip edge) the outputs track SAFE, including a
  // SAFE write landing in the same cycle; bus writes to the data path are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (tripped || trip_pulse) begin
      data <= safe_nxt;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data <= wd;
        ADDR_SET:    data <= data | wd;
        ADDR_CLR:    data <= data & ~wd;
        ADDR_TOGGLE: data <= data ^ wd;
        default:     data <= data;
      endcase
    end
  end

  // NOTE: readdata gets a default before the case so no path can infer a latch.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data);
      ADDR_WDOG_LOAD: readdata = 32'(load);
      ADDR_WDOG_KICK: readdata = 32'(cnt);
      ADDR_STATUS: begin
        readdata[ST_TRIPPED] = tripped;
        readdata[ST_RUN]     = running;
        readdata[ST_IRQEN]   = irq_en;
      end
      ADDR_SAFE:      readdata = 32'(safe);
      default:        readdata = '0;
    endcase
  end

  assign out_port = data;
  assign irq      = tripped & irq_en;

endmodule
